// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - loader handshake and instruction-memory write bus
interface imem_boot_loader_if #(
    parameter int ADDR_W = 6
);
    logic              load_req;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_start;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    modport slave (
        input  load_req, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata,
               core_start, busy, done, error, words_loaded
    );

    modport master (
        output load_req, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
               core_start, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-serial image loader into instruction memory, then core start pulse
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte after the data words.
module imem_boot_loader #(
    parameter int ADDR_W       = 6,
    parameter int START_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus
);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);
    localparam int          SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_START, S_DONE, S_ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [1:0]      lane;
    logic [23:0]     pack;
    logic [SC_W-1:0] sc_cnt;
`ifdef LOADER_CSUM_EN
    logic [7:0]      csum;
`endif

    logic        xfer;
    logic        load_ok;
    logic        last_word;
    logic [15:0] len_in;

    assign xfer      = bus.rx_valid & bus.rx_ready;
    assign load_ok   = bus.load_req & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
    assign last_word = (bus.words_loaded + 16'd1) == len;
    assign len_in    = {bus.rx_data, len_lo};

    // Status outputs are pure decodes of the state register, so they reset cleanly.
    assign bus.rx_ready   = (state == S_LEN_LO) | (state == S_LEN_HI) | (state == S_DATA) | (state == S_CSUM);
    assign bus.busy       = (state == S_LEN_LO) | (state == S_LEN_HI) | (state == S_DATA) |
                            (state == S_CSUM)   | (state == S_START);
    assign bus.core_start = (state != S_DONE);
    assign bus.done       = (state == S_DONE);
    assign bus.error      = (state == S_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (bus.load_req) state_nxt = S_LEN_LO;
            S_LEN_LO: if (xfer) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_in == 16'd0)              state_nxt = S_START;
                    else if ({1'b0, len_in} > DEPTH)  state_nxt = S_ERROR;
                    else                              state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && lane == 2'd3 && last_word) begin
`ifdef LOADER_CSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_START;
`endif
                end
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: if (xfer) state_nxt = (bus.rx_data == csum) ? S_START : S_ERROR;
`endif
            S_START: if (sc_cnt == SC_LAST) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.imem_we      <= 1'b0;
            bus.imem_addr    <= '0;
            bus.imem_wdata   <= '0;
            bus.words_loaded <= '0;
            len_lo           <= '0;
            len              <= '0;
            lane             <= '0;
            pack             <= '0;
            sc_cnt           <= '0;
`ifdef LOADER_CSUM_EN
            csum             <= '0;
`endif
        end else begin
            bus.imem_we <= 1'b0;
            // The address moves on only after the write cycle has presented it.
            if (bus.imem_we) bus.imem_addr <= bus.imem_addr + 1'b1;
            sc_cnt <= (state == S_START) ? sc_cnt + 1'b1 : '0;

            if (load_ok) begin
                bus.words_loaded <= '0;
                bus.imem_addr    <= '0;
                lane             <= '0;
`ifdef LOADER_CSUM_EN
                csum             <= '0;
`endif
            end

            if (xfer) begin
                case (state)
                    S_LEN_LO: len_lo <= bus.rx_data;
                    S_LEN_HI: len    <= len_in;
                    S_DATA: begin
                        lane <= lane + 2'd1;
`ifdef LOADER_CSUM_EN
                        csum <= csum ^ bus.rx_data;
`endif
                        case (lane)
                            2'd0: pack[7:0]   <= bus.rx_data;
                            2'd1: pack[15:8]  <= bus.rx_data;
                            2'd2: pack[23:16] <= bus.rx_data;
                            default: begin
                                bus.imem_wdata   <= {bus.rx_data, pack};
                                bus.imem_we      <= 1'b1;
                                bus.words_loaded <= bus.words_loaded + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_boot_loader #(.ADDR_W(ADDR_W), .START_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];

    wire [59:0] outs = {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                        bus.core_start, bus.busy, bus.done, bus.error, bus.words_loaded};
    localparam logic [59:0] RST_VEC = {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};

    logic [7:0] img2 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wq_addr.push_back(bus.imem_addr);
            wq_data.push_back(bus.imem_wdata);
        end
    end

    task automatic pulse_load();
        bus.load_req = 1'b1;
        @(negedge clk);
        bus.load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic lr_in_gap);
        int k = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) begin
            bus.load_req = lr_in_gap;
            @(negedge clk);
        end
        bus.load_req = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rx_ready_timeout byte=%h rx_ready=%b required=1", b, bus.rx_ready);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs !== RST_VEC) begin
            failures++;
            $display("FAIL reset_values got=%h required=%h", outs, RST_VEC);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== RST_VEC) begin
            failures++;
            $display("FAIL idle_after_reset got=%h required=%h", outs, RST_VEC);
        end
    endtask

    task automatic test_load();
        pulse_load();
        checks++;
        if ({bus.busy, bus.core_start, bus.rx_ready, bus.done, bus.words_loaded} !== {3'b111, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL load_start busy/cs/rdy/done/words=%b%b%b%b/%0d required=1110/0",
                     bus.busy, bus.core_start, bus.rx_ready, bus.done, bus.words_loaded);
        end
        wq_addr.delete(); wq_data.delete();
        for (int i = 0; i < 10; i++) send_byte(img2[i], 0, 1'b0);
        checks++;
        if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_start, bus.words_loaded} !==
            {1'b1, 6'd1, 32'h0020_0593, 1'b1, 16'd2}) begin
            failures++;
            $display("FAIL last_write we=%b addr=%0d data=%h cs=%b words=%0d required=1/1/00200593/1/2",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_start, bus.words_loaded);
        end
        @(negedge clk);
        checks++;
        if ({bus.core_start, bus.imem_we, bus.done} !== 3'b100) begin
            failures++;
            $display("FAIL start_hold cs/we/done=%b%b%b required=100", bus.core_start, bus.imem_we, bus.done);
        end
        @(negedge clk);
        checks++;
        if ({bus.core_start, bus.done, bus.busy, bus.words_loaded} !== {3'b010, 16'd2}) begin
            failures++;
            $display("FAIL start_release cs/done/busy=%b%b%b words=%0d required=010/2",
                     bus.core_start, bus.done, bus.busy, bus.words_loaded);
        end
        checks++;
        if (wq_addr.size() != 2 || wq_addr[0] !== 6'd0 || wq_data[0] !== 32'h0010_0513 ||
            wq_addr[1] !== 6'd1 || wq_data[1] !== 32'h0020_0593) begin
            failures++;
            $display("FAIL load_writes count=%0d required 2 writes 0:00100513 1:00200593", wq_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        pulse_load();
        for (int i = 0; i < 6; i++) send_byte(img2[i], 0, 1'b0);
        checks++;
        if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'h0010_0513) begin
            failures++;
            $display("FAIL mid_first_write we=%b data=%h required=1/00100513", bus.imem_we, bus.imem_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== RST_VEC) begin
            failures++;
            $display("FAIL reset_mid got=%h required=%h", outs, RST_VEC);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== RST_VEC) begin
            failures++;
            $display("FAIL reset_mid_release got=%h required=%h", outs, RST_VEC);
        end
    endtask

    task automatic test_zero_len();
        pulse_load();
        wq_addr.delete(); wq_data.delete();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        checks++;
        if ({bus.core_start, bus.busy, bus.imem_we, bus.rx_ready} !== 4'b1100) begin
            failures++;
            $display("FAIL zero_start cs/busy/we/rdy=%b%b%b%b required=1100",
                     bus.core_start, bus.busy, bus.imem_we, bus.rx_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.core_start !== 1'b1) begin
            failures++;
            $display("FAIL zero_hold cs=%b required=1", bus.core_start);
        end
        @(negedge clk);
        checks++;
        if ({bus.core_start, bus.done, bus.words_loaded} !== {2'b01, 16'd0} || wq_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_done cs/done=%b%b words=%0d writes=%0d required=01/0/0",
                     bus.core_start, bus.done, bus.words_loaded, wq_addr.size());
        end
    endtask

    task automatic test_overflow();
        pulse_load();
        wq_addr.delete(); wq_data.delete();
        send_byte(8'h41, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        checks++;
        if ({bus.error, bus.core_start, bus.rx_ready, bus.busy, bus.done} !== 5'b11000 || wq_addr.size() != 0) begin
            failures++;
            $display("FAIL overflow err/cs/rdy/busy/done=%b%b%b%b%b writes=%0d required=11000/0",
                     bus.error, bus.core_start, bus.rx_ready, bus.busy, bus.done, wq_addr.size());
        end
    endtask

    task automatic test_full_depth();
        logic [7:0] b0;
        pulse_load();
        checks++;
        if (bus.error !== 1'b0) begin
            failures++;
            $display("FAIL error_clear err=%b required=0", bus.error);
        end
        wq_addr.delete(); wq_data.delete();
        send_byte(8'h40, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        checks++;
        if ({bus.busy, bus.error, bus.rx_ready} !== 3'b101) begin
            failures++;
            $display("FAIL depth_accept busy/err/rdy=%b%b%b required=101", bus.busy, bus.error, bus.rx_ready);
        end
        for (int i = 0; i < 256; i++) send_byte(8'(i), 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.done, bus.core_start, bus.words_loaded} !== {2'b10, 16'd64} || wq_addr.size() != 64) begin
            failures++;
            $display("FAIL depth_done done/cs=%b%b words=%0d writes=%0d required=10/64/64",
                     bus.done, bus.core_start, bus.words_loaded, wq_addr.size());
        end
        for (int w = 0; w < 64 && w < wq_addr.size(); w++) begin
            b0 = 8'(4 * w);
            checks++;
            if (wq_addr[w] !== 6'(w) || wq_data[w] !== {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}) begin
                failures++;
                $display("FAIL depth_word%0d addr=%0d data=%h required=%0d/%h", w, wq_addr[w], wq_data[w],
                         w, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
            end
        end
    endtask

    task automatic test_gaps();
        int k = 0;
        int gap;
        pulse_load();
        wq_addr.delete(); wq_data.delete();
        for (int i = 0; i < 10; i++) begin
            gap = (i == 4) ? 2 : int'($urandom_range(0, 3));
            send_byte(img2[i], gap, (i >= 2) ? 1'b1 : 1'b0);
        end
        while (bus.done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ({bus.done, bus.error, bus.words_loaded} !== {2'b10, 16'd2}) begin
            failures++;
            $display("FAIL gaps_done done/err=%b%b words=%0d required=10/2", bus.done, bus.error, bus.words_loaded);
        end
        checks++;
        if (wq_addr.size() != 2 || wq_addr[0] !== 6'd0 || wq_data[0] !== 32'h0010_0513 ||
            wq_addr[1] !== 6'd1 || wq_data[1] !== 32'h0020_0593) begin
            failures++;
            $display("FAIL gaps_writes count=%0d required 2 writes 0:00100513 1:00200593", wq_addr.size());
        end
    endtask

`ifdef LOADER_CSUM_EN
    task automatic test_csum();
        logic [7:0] cs = 8'h00;
        for (int i = 2; i < 10; i++) cs = cs ^ img2[i];
        pulse_load();
        wq_addr.delete(); wq_data.delete();
        for (int i = 0; i < 10; i++) send_byte(img2[i], 0, 1'b0);
        checks++;
        if ({bus.rx_ready, bus.busy, bus.core_start, bus.imem_we} !== 4'b1111) begin
            failures++;
            $display("FAIL csum_wait rdy/busy/cs/we=%b%b%b%b required=1111",
                     bus.rx_ready, bus.busy, bus.core_start, bus.imem_we);
        end
        send_byte(cs, 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.done, bus.error, bus.core_start, bus.words_loaded} !== {3'b100, 16'd2}) begin
            failures++;
            $display("FAIL csum_good done/err/cs=%b%b%b words=%0d required=100/2",
                     bus.done, bus.error, bus.core_start, bus.words_loaded);
        end
        pulse_load();
        wq_addr.delete(); wq_data.delete();
        for (int i = 0; i < 10; i++) send_byte(img2[i], 0, 1'b0);
        send_byte(cs ^ 8'h01, 0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.done, bus.error, bus.core_start, bus.words_loaded} !== {3'b011, 16'd2} || wq_addr.size() != 2) begin
            failures++;
            $display("FAIL csum_bad done/err/cs=%b%b%b words=%0d writes=%0d required=011/2/2",
                     bus.done, bus.error, bus.core_start, bus.words_loaded, wq_addr.size());
        end
    endtask
`else
    task automatic test_trailing_byte();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hB0;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.done, bus.core_start, bus.error} !== 4'b0100) begin
            failures++;
            $display("FAIL trailing_byte rdy/done/cs/err=%b%b%b%b required=0100",
                     bus.rx_ready, bus.done, bus.core_start, bus.error);
        end
        bus.rx_valid = 1'b0;
    endtask
`endif

    initial begin
        bus.load_req = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_load();
`ifdef LOADER_CSUM_EN
        test_csum();
`else
        test_trailing_byte();
`endif
        test_reset_mid();
        test_zero_len();
        test_overflow();
        test_full_depth();
        test_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
